alu_bist: RTL

//  Built-in self-test engine for the 32-bit ALU. It drives EntradaA, EntradaB and OP into the ALU,

---
 rtl/alu_bist_if.sv | 24 ++
 rtl/alu_bist.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_if.sv
// ALU stimulus/response bundle between the BIST engine and the ALU.
// master drives operands and opcode, slave returns Saida.
interface alu_bist_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] EntradaA;
    logic [WIDTH-1:0] EntradaB;
    logic [1:0]       OP;
    logic [WIDTH-1:0] Saida;

    modport master (
        output EntradaA,
        output EntradaB,
        output OP,
        input  Saida
    );

    modport slave (
        input  EntradaA,
        input  EntradaB,
        input  OP,
        output Saida
    );
endinterface

// File: rtl/alu_bist.sv
// ALU built-in self-test: LFSR operand pairs x 4 ops, checked against a reference.
// Define ALU_BIST_DIRECTED_EN to prepend 8 directed vectors to every run.
module alu_bist #(
    parameter int          WIDTH     = 32,
    parameter int          N_VECTORS = 64,
    parameter logic [31:0] SEED      = 32'hACE12001,
    parameter int          SETTLE    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    alu_bist_if.master       alu,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_cnt,
    output logic [15:0]      fail_idx,
    output logic [WIDTH-1:0] fail_exp,
    output logic [WIDTH-1:0] fail_got
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [31:0] TAPS   = 32'h80200003;
    localparam logic [31:0] SEED_A = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] RAW_B  = SEED ^ 32'h5A5A5A5A;
    localparam logic [31:0] SEED_B = (RAW_B == 32'h0) ? 32'h1 : RAW_B;

`ifdef ALU_BIST_DIRECTED_EN
    localparam int N_DIR = 8;
`else
    localparam int N_DIR = 0;
`endif

    localparam logic [15:0] LAST_IDX = 16'(N_VECTORS + N_DIR - 1);

    state_t           state_q;
    logic [15:0]      idx_q;
    logic [15:0]      cnt_q;
    logic [31:0]      lfsr_a_q;
    logic [31:0]      lfsr_b_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [15:0]      err_q;
    logic [15:0]      fidx_q;
    logic [WIDTH-1:0] fexp_q;
    logic [WIDTH-1:0] fgot_q;

    logic [31:0]      lfsr_a_d;
    logic [31:0]      lfsr_b_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] exp_d;
    logic [15:0]      err_d;
    logic             miss_d;
    logic             dir_d;

    // Galois right-shift step
    assign lfsr_a_d = {1'b0, lfsr_a_q[31:1]} ^ (lfsr_a_q[0] ? TAPS : 32'h0);
    assign lfsr_b_d = {1'b0, lfsr_b_q[31:1]} ^ (lfsr_b_q[0] ? TAPS : 32'h0);

`ifdef ALU_BIST_DIRECTED_EN
    always_comb begin
        dir_d = (idx_q < 16'(N_DIR));
        a_d   = WIDTH'(lfsr_a_q);
        b_d   = WIDTH'(lfsr_b_q);
        if (dir_d) begin
            a_d = idx_q[2] ? '1 : WIDTH'(2001);
            b_d = idx_q[2] ? WIDTH'(1) : WIDTH'(4001);
        end
    end
`else
    always_comb begin
        dir_d = 1'b0;
        a_d   = WIDTH'(lfsr_a_q);
        b_d   = WIDTH'(lfsr_b_q);
    end
`endif

    always_comb begin
        exp_d = a_q + b_q;
        case (op_q)
            2'b01:   exp_d = a_q - b_q;
            2'b10:   exp_d = a_q & b_q;
            2'b11:   exp_d = a_q | b_q;
            default: exp_d = a_q + b_q;
        endcase
    end

    assign miss_d = (alu.Saida != exp_d);
    assign err_d  = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            lfsr_a_q <= SEED_A;
            lfsr_b_q <= SEED_B;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fidx_q   <= '0;
            fexp_q   <= '0;
            fgot_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_DRIVE;
                        idx_q    <= '0;
                        lfsr_a_q <= SEED_A;
                        lfsr_b_q <= SEED_B;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        err_q    <= '0;
                        fidx_q   <= '0;
                        fexp_q   <= '0;
                        fgot_q   <= '0;
                    end
                end
                S_DRIVE: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    op_q    <= idx_q[1:0];
                    cnt_q   <= 16'(SETTLE - 1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == 16'd0) state_q <= S_CHECK;
                    else cnt_q <= cnt_q - 16'd1;
                end
                S_CHECK: begin
                    if (miss_d) begin
                        err_q <= err_d;
                        // err_q only reads zero before the first miss of a run
                        if (err_q == 16'd0) begin
                            fidx_q <= idx_q;
                            fexp_q <= exp_d;
                            fgot_q <= alu.Saida;
                        end
                    end
                    if (!dir_d && idx_q[1:0] == 2'b11) begin
                        lfsr_a_q <= lfsr_a_d;
                        lfsr_b_q <= lfsr_b_d;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == 16'd0) && !miss_d;
                    end else begin
                        idx_q   <= idx_q + 16'd1;
                        state_q <= S_DRIVE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu.EntradaA = a_q;
    assign alu.EntradaB = b_q;
    assign alu.OP       = op_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_cnt      = err_q;
    assign fail_idx     = fidx_q;
    assign fail_exp     = fexp_q;
    assign fail_got     = fgot_q;

endmodule
